// File: rtl/ir_ac_cmd_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ir_ac_cmd_scheduler                                                        |
// | Air-conditioner settings register, IR frame encoder and frame scheduler.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ir_ac_cmd_scheduler #(
  parameter int          GAP_CYC    = 12_500_000,
  parameter int          TEMP_MIN   = 16,
  parameter int          TEMP_MAX   = 30,
  parameter int          TEMP_RST   = 26,
  parameter logic [24:0] FIXED35_LO = 25'h0000A52,
  parameter logic [27:0] FIXED32_HI = 28'h0802000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_power,
  input  logic        btn_mode,
  input  logic        btn_fan,
  input  logic        btn_temp_up,
  input  logic        btn_temp_dn,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        tx_req,
  output logic [34:0] data35,
  output logic [31:0] data32,
  output logic        cur_power,
  output logic [2:0]  cur_mode,
  output logic [1:0]  cur_fan,
  output logic [4:0]  cur_temp,
  output logic        pending
);

  localparam logic [4:0] C_TEMP_MIN = 5'(TEMP_MIN);
  localparam logic [4:0] C_TEMP_MAX = 5'(TEMP_MAX);
  localparam logic [4:0] C_TEMP_RST = 5'(TEMP_RST);
  localparam int         C_CNT_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [C_CNT_W-1:0] C_GAP_LAST = C_CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [C_CNT_W-1:0] r_gap_cnt;

  logic       w_power;
  logic [2:0] w_mode;
  logic [1:0] w_fan;
  logic [4:0] w_temp;
  logic       w_changed;
  logic [3:0] w_tc;
  logic [3:0] w_csum;

  // One button per cycle by fixed priority; while off only power is honoured
  always_comb begin
    w_power   = cur_power;
    w_mode    = cur_mode;
    w_fan     = cur_fan;
    w_temp    = cur_temp;
    w_changed = 1'b0;
    if (btn_power) begin
      w_power   = ~cur_power;
      w_changed = 1'b1;
    end else if (cur_power) begin
      if (btn_mode) begin
        w_mode    = (cur_mode == 3'd4) ? 3'd0 : cur_mode + 3'd1;
        w_changed = 1'b1;
      end else if (btn_fan) begin
        w_fan     = cur_fan + 2'd1;
        w_changed = 1'b1;
      end else if (btn_temp_up) begin
        if (cur_temp < C_TEMP_MAX) begin
          w_temp    = cur_temp + 5'd1;
          w_changed = 1'b1;
        end
      end else if (btn_temp_dn) begin
        if (cur_temp > C_TEMP_MIN) begin
          w_temp    = cur_temp - 5'd1;
          w_changed = 1'b1;
        end
      end
    end
  end

  assign w_tc   = 4'(cur_temp - C_TEMP_MIN);
  assign w_csum = {1'b0, cur_mode} + w_tc + {3'b000, cur_power} + {2'b00, cur_fan};

  always_comb begin
    w_next = r_state;
    tx_req = 1'b0;
    case (r_state)
      S_IDLE: if (pending) w_next = S_LOAD;
      S_LOAD: w_next = S_REQ;
      S_REQ: begin
        tx_req = 1'b1;
        if (tx_done)      w_next = S_GAP;
        else if (tx_busy) w_next = S_WAIT;
      end
      S_WAIT: if (tx_done) w_next = S_GAP;
      S_GAP:  if (r_gap_cnt == C_GAP_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_gap_cnt <= (r_state == S_GAP && r_gap_cnt != C_GAP_LAST) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  // A change applied during LOAD wins over the clear so it reaches the next frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_power <= 1'b0;
      cur_mode  <= 3'd1;
      cur_fan   <= 2'd0;
      cur_temp  <= C_TEMP_RST;
      pending   <= 1'b0;
      data35    <= '0;
      data32    <= '0;
    end else begin
      cur_power <= w_power;
      cur_mode  <= w_mode;
      cur_fan   <= w_fan;
      cur_temp  <= w_temp;
      if (w_changed)              pending <= 1'b1;
      else if (r_state == S_LOAD) pending <= 1'b0;
      if (r_state == S_LOAD) begin
        data35 <= {cur_mode, cur_power, cur_fan, w_tc, FIXED35_LO};
        data32 <= {FIXED32_HI, w_csum};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ir_ac_cmd_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ir_ac_cmd_scheduler                                                     |
// | Directed, table-driven self-checking bench for ir_ac_cmd_scheduler.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ir_ac_cmd_scheduler;

  localparam int GAP = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_power = 1'b0, btn_mode = 1'b0, btn_fan = 1'b0;
  logic        btn_temp_up = 1'b0, btn_temp_dn = 1'b0;
  logic        tx_busy, tx_done, tx_req, cur_power, pending;
  logic [34:0] data35;
  logic [31:0] data32;
  logic [2:0]  cur_mode;
  logic [1:0]  cur_fan;
  logic [4:0]  cur_temp;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ir_ac_cmd_scheduler #(.GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst),
    .btn_power(btn_power), .btn_mode(btn_mode), .btn_fan(btn_fan),
    .btn_temp_up(btn_temp_up), .btn_temp_dn(btn_temp_dn),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_req(tx_req),
    .data35(data35), .data32(data32),
    .cur_power(cur_power), .cur_mode(cur_mode), .cur_fan(cur_fan),
    .cur_temp(cur_temp), .pending(pending)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy two cycles after req is seen, done 50 cycles later
  int          tcnt     = 0;
  int          frames   = 0;
  int          done_cyc = -1000;
  logic [34:0] d35_q [8];
  logic [31:0] d32_q [8];

  assign tx_busy = (tcnt >= 2) && (tcnt <= 51);
  assign tx_done = (tcnt == 52);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= 0;
    end else if (tcnt == 0) begin
      if (tx_req) begin
        tcnt <= 1;
        if (frames < 8) begin
          d35_q[frames] <= data35;
          d32_q[frames] <= data32;
        end
        frames <= frames + 1;
        tests = tests + 1;
        if (cyc - done_cyc < GAP + 2) begin
          fails = fails + 1;
          $display("FAIL frame_gap: got %0d cycles, required >= %0d", cyc - done_cyc, GAP + 2);
        end
      end
    end else if (tcnt == 52) begin
      tcnt     <= 0;
      done_cyc <= cyc;
    end else begin
      tcnt <= tcnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // b = {power, mode, fan, temp_up, temp_dn}
  task automatic press(input logic [4:0] b);
    @(negedge clk);
    {btn_power, btn_mode, btn_fan, btn_temp_up, btn_temp_dn} = b;
    @(negedge clk);
    {btn_power, btn_mode, btn_fan, btn_temp_up, btn_temp_dn} = 5'b0;
  endtask

  task automatic wait_busy(input int lim);
    int k = 0;
    while (!tx_busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("busy_seen", 64'(tx_busy), 64'd1);
  endtask

  task automatic wait_frames(input int n, input int lim);
    int k = 0;
    while (frames < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("frame_count_reached", 64'(frames >= n), 64'd1);
  endtask

  typedef struct {
    logic [4:0]  btn;
    logic [10:0] exp;   // {power, mode, fan, temp}
  } vec_t;

  vec_t vt [15];
  int   f;

  initial begin
    vt[0]  = '{5'b01010, {1'b1, 3'd2, 2'd0, 5'd16}};  // mode beats temp_up
    vt[1]  = '{5'b01000, {1'b1, 3'd3, 2'd0, 5'd16}};
    vt[2]  = '{5'b01000, {1'b1, 3'd4, 2'd0, 5'd16}};
    vt[3]  = '{5'b01000, {1'b1, 3'd0, 2'd0, 5'd16}};  // mode wraps
    vt[4]  = '{5'b00101, {1'b1, 3'd0, 2'd1, 5'd16}};  // fan beats temp_dn
    vt[5]  = '{5'b00100, {1'b1, 3'd0, 2'd2, 5'd16}};
    vt[6]  = '{5'b00100, {1'b1, 3'd0, 2'd3, 5'd16}};
    vt[7]  = '{5'b00100, {1'b1, 3'd0, 2'd0, 5'd16}};  // fan wraps
    vt[8]  = '{5'b00011, {1'b1, 3'd0, 2'd0, 5'd17}};  // up beats dn
    vt[9]  = '{5'b00001, {1'b1, 3'd0, 2'd0, 5'd16}};
    vt[10] = '{5'b00001, {1'b1, 3'd0, 2'd0, 5'd16}};  // saturate low
    vt[11] = '{5'b10100, {1'b0, 3'd0, 2'd0, 5'd16}};  // power beats fan
    vt[12] = '{5'b01000, {1'b0, 3'd0, 2'd0, 5'd16}};  // ignored while off
    vt[13] = '{5'b00010, {1'b0, 3'd0, 2'd0, 5'd16}};  // ignored while off
    vt[14] = '{5'b10000, {1'b1, 3'd0, 2'd0, 5'd16}};

    // Reset values while rst is held low
    tick(2);
    check("rst_tx_req", 64'(tx_req), 64'd0);
    check("rst_data35", 64'(data35), 64'd0);
    check("rst_data32", 64'(data32), 64'd0);
    check("rst_settings", 64'({cur_power, cur_mode, cur_fan, cur_temp}), 64'({1'b0, 3'd1, 2'd0, 5'd26}));
    rst = 1'b1;

    // Idle for 1000 cycles: nothing is sent
    tick(1000);
    check("idle_frames", 64'(frames), 64'd0);
    check("idle_pending", 64'(pending), 64'd0);
    check("idle_temp", 64'(cur_temp), 64'd26);
    check("idle_mode", 64'(cur_mode), 64'd1);

    // Power on -> frame 1; three temp_up presses during WAIT coalesce into frame 2
    press(5'b10000);
    check("power_pending", 64'(pending), 64'd1);
    wait_busy(20);
    press(5'b00010);
    press(5'b00010);
    press(5'b00010);
    check("temp_29", 64'(cur_temp), 64'd29);
    wait_frames(2, 500);
    check("f1_data35", 64'(d35_q[0]), 64'({10'h0CA, 25'h0000A52}));
    check("f1_data32", 64'(d32_q[0]), 64'h0802000C);
    check("f2_data35", 64'(d35_q[1]), 64'({10'h0CD, 25'h0000A52}));
    check("f2_data32", 64'(d32_q[1]), 64'h0802000F);
    tick(400);
    check("coalesced_frames", 64'(frames), 64'd2);
    check("post_frames_pending", 64'(pending), 64'd0);
    check("data35_stable", 64'(data35), 64'({10'h0CD, 25'h0000A52}));

    // Saturation at TEMP_MAX and TEMP_MIN
    press(5'b00010);
    check("temp_30", 64'(cur_temp), 64'd30);
    tick(400);
    f = frames;
    press(5'b00010);
    check("sat_hi_temp", 64'(cur_temp), 64'd30);
    check("sat_hi_pending", 64'(pending), 64'd0);
    tick(300);
    check("sat_hi_no_frame", 64'(frames), 64'(f));
    for (int i = 0; i < 15; i++) press(5'b00001);
    check("sat_lo_temp", 64'(cur_temp), 64'd16);
    tick(400);

    // Arbitration and wrap table
    for (int i = 0; i < 15; i++) begin
      press(vt[i].btn);
      check($sformatf("vec%0d", i), 64'({cur_power, cur_mode, cur_fan, cur_temp}), 64'(vt[i].exp));
    end
    tick(400);

    // Reset during WAIT abandons the frame
    press(5'b00100);
    wait_busy(20);
    tick(5);
    rst = 1'b0;
    #1;
    check("mid_rst_tx_req", 64'(tx_req), 64'd0);
    check("mid_rst_data", 64'({data35, data32}), 64'd0);
    check("mid_rst_settings", 64'({cur_power, cur_mode, cur_fan, cur_temp, pending}),
          64'({1'b0, 3'd1, 2'd0, 5'd26, 1'b0}));
    tick(3);
    rst = 1'b1;
    f = frames;
    tick(400);
    check("post_rst_no_frame", 64'(frames), 64'(f));
    press(5'b00010);
    check("off_temp_ignored", 64'(cur_temp), 64'd26);
    check("off_no_pending", 64'(pending), 64'd0);
    tick(300);
    check("off_no_frame", 64'(frames), 64'(f));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
